// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and scancode prefix decoder
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of received bytes.
module ps2_key_decoder #(
    parameter int TIMEOUT = 8192
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_pressed,
    output logic       key_pause,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state, state_nx;
    logic           clk_s1, clk_s2, clk_prev, fe;
    logic           data_s1, data_s2, data_d;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic [CW-1:0]  to_cnt;
    logic           timeout_hit;
    logic           parity_bad;
    logic           bv_nx, ef_nx, ep_nx;
    logic           ext, rel;
    logic [2:0]     skip_cnt;

`ifdef PS2_PARITY_CHECK_EN
    logic           parity_q;
    assign parity_bad = ~(^{shift_q, parity_q});
`else
    assign parity_bad = 1'b0;
`endif

    // Clock sync flops reset high so the idle line never looks like a falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            fe       <= 1'b0;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            data_d   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            fe       <= clk_prev & ~clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
            data_d   <= data_s2;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        bv_nx       = 1'b0;
        ef_nx       = 1'b0;
        ep_nx       = 1'b0;
        case (state)
            IDLE:   if (fe && !data_d)         state_nx = DATA;
            DATA:   if (fe && bit_cnt == 3'd7) state_nx = PARITY;
            PARITY: if (fe)                    state_nx = STOP;
            STOP: begin
                if (fe) begin
                    state_nx = IDLE;
                    if (!data_d)         ef_nx = 1'b1;
                    else if (parity_bad) ep_nx = 1'b1;
                    else                 bv_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // An edge in the terminal-count cycle keeps the frame alive.
        if (state != IDLE && !fe && to_cnt == CW'(TIMEOUT)) begin
            timeout_hit = 1'b1;
            state_nx    = IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            bit_cnt     <= 3'd0;
            shift_q     <= 8'h00;
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE || fe)
                to_cnt <= '0;
            else if (!timeout_hit)
                to_cnt <= to_cnt + CW'(1);
            if (state == IDLE)
                bit_cnt <= 3'd0;
            else if (state == DATA && fe)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == DATA && fe)
                shift_q <= {data_d, shift_q[7:1]};
            byte_valid  <= bv_nx;
            err_frame   <= ef_nx;
            err_timeout <= timeout_hit;
            if (bv_nx)
                byte_data <= shift_q;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            parity_q   <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            if (state == PARITY && fe)
                parity_q <= data_d;
            err_parity <= ep_nx;
        end
    end
`else
    assign err_parity = 1'b0;
`endif

    // Prefix decoder: runs one cycle behind the byte strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext         <= 1'b0;
            rel         <= 1'b0;
            skip_cnt    <= 3'd0;
            key_strobe  <= 1'b0;
            key_pause   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            key_pause  <= 1'b0;
            if (err_frame || err_parity || err_timeout) begin
                ext      <= 1'b0;
                rel      <= 1'b0;
                skip_cnt <= 3'd0;
            end else if (byte_valid) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1)
                        key_pause <= 1'b1;
                end else begin
                    case (byte_data)
                        8'hE0: ext      <= 1'b1;
                        8'hF0: rel      <= 1'b1;
                        8'hE1: skip_cnt <= 3'd7;
                        default: begin
                            key_code    <= byte_data;
                            key_ext     <= ext;
                            key_pressed <= ~rel;
                            key_strobe  <= 1'b1;
                            ext         <= 1'b0;
                            rel         <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    logic unused_ep;
    assign unused_ep = ep_nx;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int TO = 64;
    localparam int H  = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    localparam logic [3:0] T_BYTE = 4'd1, T_KEY = 4'd2, T_PAUSE = 4'd3,
                           T_ERRP = 4'd4, T_ERRF = 4'd5, T_ERRT = 4'd6;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       byte_valid, key_strobe, key_ext, key_pressed, key_pause;
    logic       err_parity, err_frame, err_timeout;
    logic [7:0] byte_data, key_code;

    ps2_key_decoder #(.TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_valid(byte_valid), .byte_data(byte_data), .key_strobe(key_strobe),
        .key_code(key_code), .key_ext(key_ext), .key_pressed(key_pressed),
        .key_pause(key_pause), .err_parity(err_parity), .err_frame(err_frame),
        .err_timeout(err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    int cyc = 0;
    int last_bv = -100;

    bit       m_ext, m_rel;
    int       m_skip;
    logic [7:0] last_good;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [15:0] ev);
        if (exp_q.size() == 0)
            check("unexpected_event", {16'h0, ev}, 32'h0);
        else
            check("event", {16'h0, ev}, {16'h0, exp_q.pop_front()});
    endtask

    always @(negedge clk_sys) begin
        cyc++;
        if (!reset) begin
            if (byte_valid || err_parity || err_frame || err_timeout)
                check("err_excl", $countones({byte_valid, err_parity, err_frame, err_timeout}), 1);
            if (byte_valid) begin
                expect_ev({T_BYTE, 4'b0000, byte_data});
                last_bv = cyc;
            end
            if (err_parity)  expect_ev({T_ERRP, 12'h000});
            if (err_frame)   expect_ev({T_ERRF, 12'h000});
            if (err_timeout) expect_ev({T_ERRT, 12'h000});
            if (key_strobe) begin
                expect_ev({T_KEY, 2'b00, key_ext, key_pressed, key_code});
                check("key_lat", cyc - last_bv, 1);
            end
            if (key_pause) begin
                expect_ev({T_PAUSE, 12'h000});
                check("pause_lat", cyc - last_bv, 1);
            end
        end
    end

    task automatic model_clear();
        m_ext = 0; m_rel = 0; m_skip = 0;
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop);
        logic par;
        par = par_ok ? ~(^d) : (^d);
        if (!stop) begin
            exp_q.push_back({T_ERRF, 12'h000});
            model_clear();
        end else if (!par_ok && PCHK) begin
            exp_q.push_back({T_ERRP, 12'h000});
            model_clear();
        end else begin
            exp_q.push_back({T_BYTE, 4'b0000, d});
            last_good = d;
            if (m_skip > 0) begin
                m_skip--;
                if (m_skip == 0) exp_q.push_back({T_PAUSE, 12'h000});
            end else if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_rel = 1;
            else if (d == 8'hE1) m_skip = 7;
            else begin
                exp_q.push_back({T_KEY, 2'b00, m_ext, ~m_rel, d});
                m_ext = 0; m_rel = 0;
            end
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk_sys);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        ps2_data = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {byte_valid, byte_data, key_strobe, key_code, key_ext, key_pressed,
                    key_pause, err_parity, err_frame, err_timeout}, 32'h0);
    endtask

    initial begin
        model_clear();
        last_good = 8'h00;
        repeat (4) @(negedge clk_sys);
        check_outputs_zero("reset_outputs");
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_outputs_zero("post_reset_idle");

        send_frame(8'h1C, 1, 1);
        send_frame(8'hE0, 1, 1);
        send_frame(8'hF0, 1, 1);
        send_frame(8'h75, 1, 1);
        send_frame(8'h75, 1, 1);
        send_frame(8'h1C, 0, 1);

        send_frame(8'hE0, 1, 1);
        send_frame(8'h55, 1, 0);
        send_frame(8'h6B, 1, 1);

        exp_q.push_back({T_ERRT, 12'h000});
        model_clear();
        send_partial(8'hA5, 4);
        repeat (TO + 40) @(negedge clk_sys);
        send_frame(8'h29, 1, 1);

        send_frame(8'hE1, 1, 1);
        send_frame(8'h14, 1, 1);
        send_frame(8'h77, 1, 1);
        send_frame(8'hE1, 1, 1);
        send_frame(8'hF0, 1, 1);
        send_frame(8'h14, 1, 1);
        send_frame(8'hF0, 1, 1);
        send_frame(8'h77, 1, 1);

        send_frame(8'hE0, 1, 1);
        send_partial(8'h3C, 3);
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk_sys);
        check_outputs_zero("mid_frame_reset");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        send_frame(8'h1C, 1, 1);

        repeat (20) @(negedge clk_sys);
        check("queue_empty", exp_q.size(), 0);
        check("byte_data_hold", {24'h0, byte_data}, {24'h0, last_good});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
